// File: rtl/dot_accum5.sv
// ============================================================================
// Module   : dot_accum5
// Summary  : Sums LEN consecutive multiplier products into one dot-product
//            result. Optional clamping build: define DOT_ACCUM5_SAT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dot_accum5 #(
    parameter int PROD_W   = 10,
    parameter int ACC_W    = 16,
    parameter int LEN      = 8,
    parameter int MULT_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [PROD_W-1:0] prod,
    input  logic              flush,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              busy
);

    localparam int                 c_CNT_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0]   c_ACC_MAX  = '1;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_ACCUM = 1'b1;

    logic [MULT_LAT-1:0] r_vpipe;
    logic [0:0]          r_state;
    logic [ACC_W-1:0]    r_acc;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_ovf_s;

    logic                w_v_d;
    logic [ACC_W:0]      w_sum;
    logic                w_carry;
    logic [ACC_W-1:0]    w_nxt;
    logic                w_last;
    logic                w_emit;

    // Valid delay line that tracks the multiplier pipeline
    generate
        if (MULT_LAT == 1) begin : g_pipe_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= op_valid;
                end
            end
        end else begin : g_pipe_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= {r_vpipe[MULT_LAT-2:0], op_valid};
                end
            end
        end
    endgenerate

    assign w_v_d   = r_vpipe[MULT_LAT-1];
    assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign w_carry = w_v_d & w_sum[ACC_W];

`ifdef DOT_ACCUM5_SAT_EN
    // Once overflow has been seen the accumulator pins at full scale
    assign w_nxt = (r_ovf_s | w_carry) ? c_ACC_MAX : w_sum[ACC_W-1:0];
`else
    assign w_nxt = w_sum[ACC_W-1:0];
`endif

    assign w_last = (r_cnt == c_CNT_LAST);
    assign w_emit = (w_v_d && w_last)
                  || (flush && (r_state == c_ST_ACCUM))
                  || (flush && w_v_d && (r_state == c_ST_IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_s   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= w_emit;
            if (w_emit) begin
                out_sum <= w_v_d ? w_nxt : r_acc;
                out_ovf <= r_ovf_s | w_carry;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ovf_s <= 1'b0;
                r_state <= c_ST_IDLE;
            end else if (w_v_d) begin
                r_acc   <= w_nxt;
                r_cnt   <= r_cnt + 1'b1;
                r_ovf_s <= r_ovf_s | w_carry;
                r_state <= c_ST_ACCUM;
            end
        end
    end

    assign busy = (r_state == c_ST_ACCUM) | (|r_vpipe);

endmodule

`default_nettype wire

// File: tb/tb_dot_accum5.sv
// ============================================================================
// Module   : tb_dot_accum5
// Summary  : Randomized scoreboard bench for dot_accum5 with a 2-stage
//            multiplier stand-in and a group-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dot_accum5;

    localparam int PROD_W   = 10;
    localparam int ACC_W    = 11;
    localparam int LEN      = 4;
    localparam int MULT_LAT = 2;
    localparam int c_HIST   = 8192;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              op_valid = 1'b0;
    logic              flush = 1'b0;
    logic [PROD_W-1:0] prod;
    logic              out_valid;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    logic [4:0]        r_ma = '0;
    logic [4:0]        r_mb = '0;
    logic [PROD_W-1:0] r_m1;

    typedef struct {
        longint sum;
        bit     ovf;
        int     at;
    } exp_t;

    exp_t   q[$];
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    longint m_sum = 0;
    int     m_n   = 0;
    bit     hv[0:c_HIST-1];
    int     hp[0:c_HIST-1];

    dot_accum5 #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .LEN(LEN), .MULT_LAT(MULT_LAT)
    ) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .prod(prod), .flush(flush),
        .out_valid(out_valid), .out_sum(out_sum), .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in 5x5 multiplier: input register then output register
    always @(posedge clk) begin
        r_m1 <= r_ma * r_mb;
        prod <= r_m1;
        cyc  <= cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input int k);
        exp_t   e;
        longint lim = longint'(1) << ACC_W;
        e.ovf = (m_sum >= lim);
`ifdef DOT_ACCUM5_SAT_EN
        e.sum = e.ovf ? lim - 1 : m_sum;
`else
        e.sum = m_sum % lim;
`endif
        e.at = k + 1;
        q.push_back(e);
    endfunction

    // Interval k sees the product issued MULT_LAT intervals earlier
    function automatic void model_step(input int k, input bit f);
        bit arr = (k >= MULT_LAT) && hv[k-MULT_LAT];
        if (arr) begin
            m_sum += hp[k-MULT_LAT];
            m_n++;
        end
        if ((m_n == LEN) || (f && m_n > 0)) begin
            push_exp(k);
            m_sum = 0;
            m_n   = 0;
        end
    endfunction

    task automatic cycle(input bit v, input int a, input int b, input bit f);
        int  k;
        bit  exp_busy;
        @(negedge clk);
        k = cyc;
        if (k >= c_HIST) begin
            $display("FAIL history: cycle budget %0d exceeded", c_HIST);
            $fatal(1);
        end
        exp_busy = (m_n > 0) || (k >= 1 && hv[k-1]) || (k >= 2 && hv[k-2]);
        chk("busy", longint'(busy), longint'(exp_busy));
        rst      = 1'b0;
        op_valid = v;
        flush    = f;
        r_ma     = a[4:0];
        r_mb     = b[4:0];
        hv[k]    = v;
        hp[k]    = a * b;
        model_step(k, f);
    endtask

    task automatic do_reset(input int n);
        int k;
        repeat (n) begin
            @(negedge clk);
            k        = cyc;
            rst      = 1'b1;
            op_valid = 1'b0;
            flush    = 1'b0;
            hv[k]    = 1'b0;
            if (k >= 1) hv[k-1] = 1'b0;
            m_sum    = 0;
            m_n      = 0;
        end
    endtask

    task automatic issue(input int a, input int b);
        cycle(1'b1, a, b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, 0, 1'b0);
    endtask

    // Monitor: pop one expectation per out_valid pulse
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_sum", longint'(out_sum), e.sum);
                chk("out_ovf", longint'(out_ovf), longint'(e.ovf));
                chk("out_latency_cycle", longint'(cyc), longint'(e.at));
            end
        end
    end

    initial begin
        for (int i = 0; i < c_HIST; i++) begin
            hv[i] = 1'b0;
            hp[i] = 0;
        end

        do_reset(2);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 0, 0, 1'b0);
            chk("idle_out_valid", longint'(out_valid), 0);
            chk("idle_out_sum", longint'(out_sum), 0);
            chk("idle_out_ovf", longint'(out_ovf), 0);
        end

        // 3,5,7,9 -> 24
        issue(3, 1); issue(5, 1); issue(7, 1); issue(9, 1);
        idle(5);

        // two back-to-back groups of 10s
        repeat (8) issue(2, 5);
        idle(5);

        // 2,4,6 with flush on the third product's arrival, then 1,1,1,1
        issue(2, 1); issue(4, 1); issue(6, 1);
        cycle(1'b0, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1);
        repeat (4) issue(1, 1);
        idle(5);

        // flush in ACCUM with no product arriving
        issue(3, 3); issue(4, 4);
        idle(3);
        cycle(1'b0, 0, 0, 1'b1);
        idle(3);

        // flush in IDLE with nothing arriving is ignored
        cycle(1'b0, 0, 0, 1'b1);
        idle(4);

        // overflow group of 31*31
        repeat (4) issue(31, 31);
        idle(5);

        // reset mid-group, then a clean group of ones
        issue(1, 1); issue(1, 1);
        do_reset(1);
        idle(4);
        repeat (4) issue(1, 1);
        idle(5);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset(1);
            end else begin
                cycle(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                      int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0);
            end
        end

        // bias toward large products to exercise overflow
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, int'($urandom_range(24, 31)), int'($urandom_range(24, 31)),
                  ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
        end

        idle(10);
        chk("pending_expected_outputs", longint'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
